// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter -- iterative DES decryption engine, one Feistel round per clock.
//
// A block is accepted in IDLE, passes through 16 round cycles and then waits in DONE
// until the result is taken. The reverse key schedule is produced on the fly by
// rotating C/D right, so no subkey store is needed.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  input handshake for cipher_text/cipher_key
//   cipher_text [63:0] block to decrypt (bit 63 = DES bit 1)
//   cipher_key  [63:0] key incl. parity bits (bit 63 = DES bit 1, parity ignored)
//   out_valid/out_ready output handshake for plain_text
//   plain_text  [63:0] result, registered and held while out_valid
//   busy               high while a block is in flight (ROUND or DONE)
//
// Optional feature: define DES_DEC_ENC_MODE_EN to add input enc_mode (sampled at
// accept). enc_mode=1 runs the forward key schedule (left rotation), i.e. DES
// encryption; enc_mode=0 decrypts.

module des_decrypt_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_text,
    input  logic [63:0] cipher_key,
`ifdef DES_DEC_ENC_MODE_EN
    input  logic        enc_mode,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_text,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Tables list the source DES bit number (1 = MSB) for each output bit, MSB first.
    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
        62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
        57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
        61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    localparam int FP_T [64] = '{
        40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
        38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
        36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
        34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int P_T [32] = '{
        16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27,
        19,11, 3,60,52,44,36, 63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
        14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{
        14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    // S-boxes S1..S8, each 4 rows x 16 columns, addressed {box, row, col}.
    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] e_f(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] p_f(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four the column.
    function automatic logic [31:0] s_f(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        for (int i = 0; i < 8; i++) begin
            six = x[6'(47 - 6 * i) -: 6];
            y[5'(31 - 4 * i) -: 4] = 4'(SBOX[{3'(i), six[5], six[0], six[4:1]}]);
        end
        return y;
    endfunction

    // DES bit 1 is the MSB, so a DES "left" rotation moves bits toward the MSB.
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                          input logic left);
        logic [27:0] y;
        case (n)
            2'd0:    y = x;
            2'd1:    y = left ? {x[26:0], x[27]}    : {x[0], x[27:1]};
            default: y = left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
        endcase
        return y;
    endfunction

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] l, r;
    logic [27:0] c, d;

    logic        rot_left;
    logic [1:0]  shamt;
    logic [27:0] c_rot, d_rot;
    logic [31:0] l_nxt, r_nxt;

`ifdef DES_DEC_ENC_MODE_EN
    logic enc_q;
    assign rot_left = enc_q;
`else
    assign rot_left = 1'b0;
`endif

    // Decrypt starts from K16 (= PC1 output, no shift) and walks back; encrypt
    // shifts before the first round. The two schedules differ only in round 1.
    always_comb begin
        shamt = 2'd2;
        case (cnt)
            5'd1:                shamt = rot_left ? 2'd1 : 2'd0;
            5'd2, 5'd9, 5'd16:   shamt = 2'd1;
            default:             shamt = 2'd2;
        endcase
    end

    assign c_rot = rot28(c, shamt, rot_left);
    assign d_rot = rot28(d, shamt, rot_left);
    assign l_nxt = r;
    assign r_nxt = l ^ p_f(s_f(e_f(r) ^ pc2_f({c_rot, d_rot})));

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 5'd0;
            l          <= 32'h0;
            r          <= 32'h0;
            c          <= 28'h0;
            d          <= 28'h0;
            plain_text <= 64'h0;
`ifdef DES_DEC_ENC_MODE_EN
            enc_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        {l, r} <= ip_f(cipher_text);
                        {c, d} <= pc1_f(cipher_key);
                        cnt    <= 5'd1;
                        state  <= S_ROUND;
`ifdef DES_DEC_ENC_MODE_EN
                        enc_q  <= enc_mode;
`endif
                    end
                end
                S_ROUND: begin
                    if (cnt < 5'd1 || cnt > 5'd16) begin
                        // Corrupted counter: bail out rather than spin.
                        state <= S_DONE;
                    end else begin
                        c <= c_rot;
                        d <= d_rot;
                        l <= l_nxt;
                        r <= r_nxt;
                        if (cnt == 5'd16) begin
                            // Undo the last swap: output is FP(R16 || L16).
                            plain_text <= fp_f({r_nxt, l_nxt});
                            state      <= S_DONE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Testbench for des_decrypt_iter: randomized and known-answer blocks checked by a
// scoreboard against a textbook DES model (full subkey list, applied in reverse).

module tb_des_decrypt_iter;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, enc_mode;
    logic        in_ready, out_valid, busy;
    logic [63:0] cipher_text, cipher_key, plain_text;

    always #5 clk = ~clk;

    des_decrypt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cipher_text(cipher_text), .cipher_key(cipher_key),
`ifdef DES_DEC_ENC_MODE_EN
        .enc_mode(enc_mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .plain_text(plain_text), .busy(busy));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;

    typedef struct { logic [63:0] exp; int acc; } exp_t;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // All permutation tables back to back: IP@0, FP@64, E@128, P@176, PC1@208, PC2@264.
    localparam int PT [312] = '{
        58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7,
        40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25,
        32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
        16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1,
        16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25,
        57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
        63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4,
        14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    localparam int SB [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Output bit j (1-based, MSB first) of an n-bit result takes source DES bit PT[off+j-1].
    function automatic logic [63:0] permute(input logic [63:0] src, input int src_w,
                                            input int off, input int n);
        logic [63:0] y = '0;
        for (int j = 0; j < n; j++) y[6'(n - 1 - j)] = src[6'(src_w - PT[off + j])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] k);
        logic [63:0] t;
        logic [47:0] x;
        logic [31:0] s = '0;
        int six, row, col;
        t = permute({32'h0, rr}, 32, 128, 48);
        x = t[47:0] ^ k;
        for (int b = 0; b < 8; b++) begin
            six = int'((x >> (42 - 6 * b)) & 48'h3f);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s = {s[27:0], 4'(SB[b * 64 + row * 16 + col])};
        end
        t = permute({32'h0, s}, 32, 176, 32);
        return t[31:0];
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] blk, key, input bit dec);
        logic [47:0] ks [16];
        logic [63:0] t;
        logic [27:0] c, d;
        logic [31:0] l, r, tmp;
        t = permute(key, 64, 208, 56);
        c = t[55:28];
        d = t[27:0];
        for (int i = 0; i < 16; i++) begin
            c = (c << SHIFTS[i]) | (c >> (28 - SHIFTS[i]));
            d = (d << SHIFTS[i]) | (d >> (28 - SHIFTS[i]));
            t = permute({8'h0, c, d}, 56, 264, 48);
            ks[i] = t[47:0];
        end
        t = permute(blk, 64, 0, 64);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r = l ^ feistel(r, dec ? ks[15 - i] : ks[i]);
            l = tmp;
        end
        return permute({r, l}, 64, 64, 64);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the head of the scoreboard every cycle out_valid is up
    // (so the result must stay stable) and pops on the handshake.
    bit prev_ov = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard (cycle %0d)",
                             plain_text, cyc);
                end else begin
                    if (!prev_ov) chk("latency", 64'(cyc - sbq[0].acc), 64'd16);
                    chk("plain_text", plain_text, sbq[0].exp);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        last_hs = cyc + 1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [63:0] key, ct, exp, input logic enc, output int acc);
        int w = 0;
        @(posedge clk); #1;
        cipher_key  = key;
        cipher_text = ct;
        enc_mode    = enc;
        in_valid    = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 (cycle %0d)", cyc);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        sbq.push_back('{exp, acc});
    endtask

    task automatic drain();
        int w = 0;
        while ((sbq.size() != 0 || busy) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_done", 64'(sbq.size()), 64'd0);
    endtask

    bit rand_ready = 1'b0;

    initial begin : main
        int a1, a2;
        logic [63:0] k, pt, ct;
        bit never;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; enc_mode = 1'b0;
        cipher_text = '0; cipher_key = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_plain_text", plain_text, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // FIPS vector, plus state checks while rounds run
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b0, a1);
        @(negedge clk);
        chk("round_busy", 64'(busy), 64'd1);
        chk("round_in_ready", 64'(in_ready), 64'd0);
        drain();

        // all-zero / all-one keys back to back: one block per 18 cycles
        send(64'h0, 64'h8CA64DE9C1B123A7, 64'h0, 1'b0, a1);
        send(64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 1'b0, a2);
        chk("throughput", 64'(a2 - a1), 64'd18);
        drain();

        // backpressure: result held, new block waits until one cycle after handshake
        out_ready = 1'b0;
        k  = 64'h0E329232EA6D0D73;
        pt = 64'h8787878787878787;
        send(k, des_ref(pt, k, 1'b0), pt, 1'b0, a1);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        fork
            send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b0, a2);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("bp_accept_after_hs", 64'(a2 - last_hs), 64'd1);
        drain();

        // reset at round 8 discards the block
        send(64'h0, 64'h8CA64DE9C1B123A7, 64'h0, 1'b0, a1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        never = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) never = 1'b0;
        end
        chk("midrst_no_output", 64'(never), 64'd1);
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b0, a1);
        drain();

        // random keys/blocks with random downstream stalls
        rand_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    k  = {$urandom, $urandom};
                    pt = {$urandom, $urandom};
                    ct = des_ref(pt, k, 1'b0);
                    send(k, ct, pt, 1'b0, a1);
                end
                drain();
                rand_ready = 1'b0;
            end
            begin
                while (rand_ready) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join

`ifdef DES_DEC_ENC_MODE_EN
        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b1, a1);
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b0, a1);
        for (int n = 0; n < 3; n++) begin
            k  = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            send(k, pt, des_ref(pt, k, 1'b0), 1'b1, a1);
        end
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
